// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter for the register file write port, with an optional busy scoreboard built when WB_ARB_SCOREBOARD_EN is defined
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] wb_D,
  output logic [ADDR_WIDTH-1:0] wb_DA,
  output logic                  wb_W,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  output logic [31:0]           busy
);
  logic                  prio;
  logic                  xfer;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  assign req0_ready = req0_valid & (~req1_valid | ~prio);
  assign req1_ready = req1_valid & (~req0_valid | prio);
  assign xfer       = req0_ready | req1_ready;
  assign sel_addr   = req1_ready ? req1_addr : req0_addr;
  assign sel_data   = req1_ready ? req1_data : req0_data;
  assign commit     = xfer & (sel_addr != ADDR_WIDTH'(31));
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prio  <= 1'b0;
      wb_W  <= 1'b0;
      wb_D  <= '0;
      wb_DA <= '0;
    end else begin
      if (xfer) prio <= req0_ready;
      wb_W <= commit;
      if (commit) begin
        wb_D  <= sel_data;
        wb_DA <= sel_addr;
      end
    end
  end
`ifdef WB_ARB_SCOREBOARD_EN
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  always_comb begin
    set_mask = (issue_valid && issue_addr != ADDR_WIDTH'(31)) ? 32'(1) << issue_addr : '0;
    clr_mask = wb_W ? 32'(1) << wb_DA : '0;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= ((busy & ~clr_mask) | set_mask) & 32'h7fff_ffff;
  end
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_addr};
  assign busy = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        v0 = 0, v1 = 0, iv = 0;
  logic [4:0]  a0 = 0, a1 = 0, ia = 0;
  logic [63:0] d0 = 0, d1 = 0;
  logic        r0, r1, wbw;
  logic [4:0]  wbda;
  logic [63:0] wbd;
  logic [31:0] busy;
  int          n_vec = 0, n_err = 0;
  logic        mprio = 0, mw = 0;
  logic [4:0]  mda = 0;
  logic [63:0] md = 0;
  logic [31:0] mbusy = 0;
  logic [68:0] q[$];
  logic        g0, g1;
  always #5 clock = ~clock;
  regfile_wb_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1),
    .wb_D(wbd), .wb_DA(wbda), .wb_W(wbw),
    .issue_valid(iv), .issue_addr(ia), .busy(busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_busy();
`ifdef WB_ARB_SCOREBOARD_EN
    return mbusy;
`else
    return 32'h0;
`endif
  endfunction
  task automatic model_reset();
    mprio = 0; mw = 0; mda = 0; md = 0; mbusy = 0;
    q.delete();
  endtask
  task automatic step(output logic o0, output logic o1);
    logic [68:0] e;
    logic [4:0]  sa;
    logic [63:0] sd;
    logic [31:0] nb;
    #1;
    o0 = v0 && (!v1 || !mprio);
    o1 = v1 && (!v0 || mprio);
    check("ready0", r0, o0);
    check("ready1", r1, o1);
    sa = o1 ? a1 : a0;
    sd = o1 ? d1 : d0;
    if (o0 || o1) begin
      mprio = o0;
      if (sa != 5'd31) q.push_back({sa, sd});
    end
    nb = mbusy & ~(mw ? 32'(1) << mda : 32'h0);
    if (iv && ia != 5'd31) nb |= 32'(1) << ia;
    nb[31] = 1'b0;
    @(posedge clock);
    #1;
    mbusy = nb;
    if (q.size() > 0) begin
      e = q.pop_front();
      mw = 1; mda = e[68:64]; md = e[63:0];
      check("wb_W commit", wbw, 1);
    end else begin
      mw = 0;
      check("wb_W idle", wbw, 0);
    end
    check("wb_DA", wbda, mda);
    check("wb_D", wbd, md);
    check("busy", busy, exp_busy());
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst wb_W", wbw, 0);
    check("rst wb_DA", wbda, 0);
    check("rst wb_D", wbd, 0);
    check("rst busy", busy, 0);
    v0 = 1; #1;
    check("rst ready0 follows valid", r0, 1);
    check("rst ready1 idle", r1, 0);
    v0 = 0;
    @(negedge clock) reset = 1;
    @(posedge clock); #1;
    model_reset();
    v0 = 1; a0 = 9; d0 = 64'h1234;
    step(g0, g1);
    v0 = 0;
    reset = 0; #1;
    model_reset();
    check("midreset wb_W", wbw, 0);
    check("midreset wb_DA", wbda, 0);
    check("midreset wb_D", wbd, 0);
    @(negedge clock) reset = 1;
    @(posedge clock); #1;
    v1 = 1; a1 = 4; d1 = 64'hAA;
    step(g0, g1);
    v1 = 0;
    v0 = 1; v1 = 1; a0 = 1; d0 = 64'h100; a1 = 2; d1 = 64'h200;
    for (int i = 0; i < 4; i++) begin
      step(g0, g1);
      if (g0) begin a0 = a0 + 5'd2; d0 = d0 + 64'h11; end
      if (g1) begin a1 = a1 + 5'd2; d1 = d1 + 64'h22; end
    end
    v1 = 0;
    a0 = 31; d0 = 64'hFF;
    step(g0, g1);
    v0 = 1; v1 = 1; a0 = 12; d0 = 64'hC0DE; a1 = 13; d1 = 64'hBEEF;
    step(g0, g1);
    v1 = 0;
    step(g0, g1);
    v0 = 0;
    iv = 1; ia = 7;
    step(g0, g1);
    iv = 0; v0 = 1; a0 = 7; d0 = 64'h77;
    step(g0, g1);
    v0 = 0;
    repeat (2) step(g0, g1);
    iv = 1; ia = 7;
    step(g0, g1);
    iv = 0; v0 = 1; a0 = 7; d0 = 64'h78;
    step(g0, g1);
    v0 = 0; iv = 1; ia = 7;
    step(g0, g1);
    iv = 1; ia = 31;
    step(g0, g1);
    iv = 0;
    step(g0, g1);
    for (int i = 0; i < 300; i++) begin
      if (!v0) begin v0 = 1'($urandom); a0 = 5'($urandom); d0 = {$urandom, $urandom}; end
      if (!v1) begin v1 = 1'($urandom); a1 = 5'($urandom); d1 = {$urandom, $urandom}; end
      iv = 1'($urandom); ia = 5'($urandom);
      step(g0, g1);
      if (g0) v0 = 0;
      if (g1) v1 = 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
